stonyman_row_assembler: RTL and testbench

- Producer end of the `img_buf_newline` / `frame_capture_done` interface consumed by `pupil_detect`.
- Accepts one pixel per beat from the Stonyman ADC readout path and packs each row into a full-width line register.
- Presents each complete row to the consumer with a valid/ack handshake.
- Asserts `frame_capture_done` once the last row of the frame has been accepted.

---
 rtl/stonyman_pkg.sv | 13 +
 rtl/stonyman_row_assembler_pixel_column_writer.sv | 64 ++++++
 rtl/stonyman_row_assembler.sv | 126 ++++++++++++
 tb/tb_stonyman_row_assembler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stonyman_pkg.sv
// Shared definitions for the Stonyman capture path (row assembler and pupil_detect).
package stonyman_pkg;

  localparam int RESOLUTION_DEF = 112;
  localparam int PIXEL_W_DEF    = 8;
  localparam int ROW_W_DEF      = RESOLUTION_DEF * PIXEL_W_DEF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/stonyman_row_assembler_pixel_column_writer.sv
// Column counter and assembly buffer for one sensor row; PIXEL_BINARIZE_EN stores
// thresholded pixels instead of raw samples.
module pixel_column_writer
  import stonyman_pkg::*;
#(
  parameter int RESOLUTION = RESOLUTION_DEF,
  parameter int PIXEL_W    = PIXEL_W_DEF
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            write_en,
  input  logic [PIXEL_W-1:0]              pixel_data,
  input  logic [PIXEL_W-1:0]              threshold,
  output logic [RESOLUTION*PIXEL_W-1:0]   row_next,
  output logic                            row_done
);

  localparam int COL_W = $clog2(RESOLUTION);
  localparam int ROW_W = RESOLUTION * PIXEL_W;

  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   buf_q, buf_d;
  logic [PIXEL_W-1:0] stored;

`ifdef PIXEL_BINARIZE_EN
  // Dark pupil pixels become all-ones so the detector can simply count set bits.
  assign stored = (pixel_data < threshold) ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign stored = pixel_data;
`endif

  always_comb begin
    col_d    = col_q;
    buf_d    = buf_q;
    row_done = 1'b0;
    if (clear) col_d = '0;
    if (write_en) begin
      buf_d[col_d*PIXEL_W +: PIXEL_W] = stored;
      if (!clear && col_q == COL_W'(RESOLUTION - 1)) begin
        col_d    = '0;
        row_done = 1'b1;
      end else begin
        col_d = col_d + 1'b1;
      end
    end
  end

  // Next-state buffer is exported so the completed row can be captured on the same edge.
  assign row_next = buf_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      col_q <= '0;
      buf_q <= '0;
    end else begin
      col_q <= col_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/stonyman_row_assembler.sv
// Packs Stonyman pixels into rows and hands them to pupil_detect via valid/ack.
// Optional build macro: PIXEL_BINARIZE_EN (thresholded pixel storage).
module stonyman_row_assembler
  import stonyman_pkg::*;
#(
  parameter int RESOLUTION = RESOLUTION_DEF,
  parameter int PIXEL_W    = PIXEL_W_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [PIXEL_W-1:0]            pixel_data,
  input  logic                          pixel_valid,
  input  logic [PIXEL_W-1:0]            threshold,
  input  logic                          row_ack,
  output logic [RESOLUTION*PIXEL_W-1:0] img_buf_newline,
  output logic                          newline_valid,
  output logic [7:0]                    row_index,
  output logic                          frame_capture_done,
  output logic                          overrun
);

  localparam int ROW_CNT_W = $clog2(RESOLUTION);
  localparam int ROW_W     = RESOLUTION * PIXEL_W;

  logic [1:0]           state_q, state_d;
  logic [ROW_CNT_W-1:0] row_q, row_d;
  logic [ROW_W-1:0]     line_q, line_d;
  logic                 valid_q, valid_d;
  logic [7:0]           index_q, index_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic                 write_en;
  logic                 row_done;
  logic [ROW_W-1:0]     row_next;

  assign write_en = pixel_valid && (state_q == ST_FILL || frame_start);

  pixel_column_writer #(
    .RESOLUTION (RESOLUTION),
    .PIXEL_W    (PIXEL_W)
  ) u_writer (
    .clock      (clock),
    .reset      (reset),
    .clear      (frame_start),
    .write_en   (write_en),
    .pixel_data (pixel_data),
    .threshold  (threshold),
    .row_next   (row_next),
    .row_done   (row_done)
  );

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    line_d    = line_q;
    valid_d   = valid_q;
    index_d   = index_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    if (frame_start) begin
      state_d   = ST_FILL;
      row_d     = '0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (row_ack) valid_d = 1'b0;
      case (state_q)
        ST_FILL: begin
          if (row_done) begin
            // An ack on the same edge frees the slot, so the new row loads without a gap.
            if (!valid_q || row_ack) begin
              line_d  = row_next;
              valid_d = 1'b1;
              index_d = 8'(row_q);
            end else begin
              overrun_d = 1'b1;
            end
            if (row_q == ROW_CNT_W'(RESOLUTION - 1)) begin
              row_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!valid_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      line_q    <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      line_q    <= line_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign img_buf_newline    = line_q;
  assign newline_valid      = valid_q;
  assign row_index          = index_q;
  assign frame_capture_done = done_q;
  assign overrun            = overrun_q;

endmodule

// File: tb/tb_stonyman_row_assembler.sv
// Directed bench for stonyman_row_assembler; works with or without PIXEL_BINARIZE_EN.
module tb_stonyman_row_assembler;

  localparam int RES   = 112;
  localparam int PW    = 8;
  localparam int ROW_W = RES * PW;
  localparam logic [7:0] THR = 8'h40;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             frame_start = 1'b0;
  logic [PW-1:0]    pixel_data = '0;
  logic             pixel_valid = 1'b0;
  logic [PW-1:0]    threshold = THR;
  logic             row_ack = 1'b0;
  logic [ROW_W-1:0] img_buf_newline;
  logic             newline_valid;
  logic [7:0]       row_index;
  logic             frame_capture_done;
  logic             overrun;

  int checkCount = 0;
  int passCount  = 0;

  stonyman_row_assembler #(.RESOLUTION(RES), .PIXEL_W(PW)) dut (
    .clock              (clock),
    .reset              (reset),
    .frame_start        (frame_start),
    .pixel_data         (pixel_data),
    .pixel_valid        (pixel_valid),
    .threshold          (threshold),
    .row_ack            (row_ack),
    .img_buf_newline    (img_buf_newline),
    .newline_valid      (newline_valid),
    .row_index          (row_index),
    .frame_capture_done (frame_capture_done),
    .overrun            (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] expPixel(input logic [7:0] p);
`ifdef PIXEL_BINARIZE_EN
    return (p < THR) ? 8'hFF : 8'h00;
`else
    return p;
`endif
  endfunction

  // Row r carries pixel value (r + c) mod 256 in column c.
  function automatic logic [ROW_W-1:0] expRow(input int r);
    logic [ROW_W-1:0] e;
    e = '0;
    for (int c = 0; c < RES; c++) e[c*PW +: PW] = expPixel(8'(r + c));
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sendPixels(input int r, input int startCol, input int count);
    for (int c = startCol; c < startCol + count; c++) begin
      pixel_data  = 8'(r + c);
      pixel_valid = 1'b1;
      tick();
    end
    pixel_valid = 1'b0;
  endtask

  task automatic pulseStart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulseAck();
    row_ack = 1'b1;
    tick();
    row_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    tick();
    tick();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    checkCount++; if (newline_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", newline_valid); else passCount++;
    checkCount++; if (frame_capture_done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", frame_capture_done); else passCount++;
    checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); else passCount++;
    checkCount++; if (row_index !== 8'd0) $display("[TB] FAIL reset_row_index: got %0d expected 0", row_index); else passCount++;
    checkCount++; if (img_buf_newline !== '0) $display("[TB] FAIL reset_line: got %h expected 0", img_buf_newline); else passCount++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_first_row();
    pulseStart();
    sendPixels(0, 0, RES - 1);
    checkCount++; if (newline_valid !== 1'b0) $display("[TB] FAIL first_early_valid: got %b expected 0", newline_valid); else passCount++;
    sendPixels(0, RES - 1, 1);
    checkCount++; if (newline_valid !== 1'b1) $display("[TB] FAIL first_valid: got %b expected 1", newline_valid); else passCount++;
    checkCount++; if (row_index !== 8'd0) $display("[TB] FAIL first_row_index: got %0d expected 0", row_index); else passCount++;
    checkCount++; if (img_buf_newline !== expRow(0)) $display("[TB] FAIL first_data: got %h expected %h", img_buf_newline, expRow(0)); else passCount++;
    pulseAck();
    checkCount++; if (newline_valid !== 1'b0) $display("[TB] FAIL first_ack_clear: got %b expected 0", newline_valid); else passCount++;
  endtask

  task automatic test_full_frame();
    int waitCycles;
    pulseStart();
    for (int r = 0; r < RES; r++) begin
      sendPixels(r, 0, RES);
      checkCount++; if (newline_valid !== 1'b1) $display("[TB] FAIL frame_valid r%0d: got %b expected 1", r, newline_valid); else passCount++;
      checkCount++; if (row_index !== 8'(r)) $display("[TB] FAIL frame_row_index: got %0d expected %0d", row_index, r); else passCount++;
      checkCount++; if (img_buf_newline !== expRow(r)) $display("[TB] FAIL frame_data r%0d: got %h expected %h", r, img_buf_newline, expRow(r)); else passCount++;
      if (r == RES - 1) begin
        checkCount++; if (frame_capture_done !== 1'b0) $display("[TB] FAIL frame_done_early: got %b expected 0", frame_capture_done); else passCount++;
      end
      pulseAck();
    end
    waitCycles = 0;
    while (frame_capture_done !== 1'b1 && waitCycles < 5) begin
      tick();
      waitCycles++;
    end
    checkCount++; if (frame_capture_done !== 1'b1) $display("[TB] FAIL frame_done: got %b expected 1", frame_capture_done); else passCount++;
    checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL frame_overrun: got %b expected 0", overrun); else passCount++;
    tick();
    checkCount++; if (frame_capture_done !== 1'b1) $display("[TB] FAIL frame_done_held: got %b expected 1", frame_capture_done); else passCount++;
  endtask

  task automatic test_overrun();
    pulseStart();
    checkCount++; if (frame_capture_done !== 1'b0) $display("[TB] FAIL restart_done_clear: got %b expected 0", frame_capture_done); else passCount++;
    sendPixels(0, 0, RES);
    sendPixels(1, 0, RES);
    checkCount++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); else passCount++;
    checkCount++; if (newline_valid !== 1'b1) $display("[TB] FAIL ovr_valid: got %b expected 1", newline_valid); else passCount++;
    checkCount++; if (row_index !== 8'd0) $display("[TB] FAIL ovr_row_index: got %0d expected 0", row_index); else passCount++;
    checkCount++; if (img_buf_newline !== expRow(0)) $display("[TB] FAIL ovr_data_kept: got %h expected %h", img_buf_newline, expRow(0)); else passCount++;
    pulseAck();
    checkCount++; if (newline_valid !== 1'b0) $display("[TB] FAIL ovr_ack_clear: got %b expected 0", newline_valid); else passCount++;
    sendPixels(2, 0, RES);
    checkCount++; if (row_index !== 8'd2) $display("[TB] FAIL ovr_next_index: got %0d expected 2", row_index); else passCount++;
    checkCount++; if (img_buf_newline !== expRow(2)) $display("[TB] FAIL ovr_next_data: got %h expected %h", img_buf_newline, expRow(2)); else passCount++;
    checkCount++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); else passCount++;
    pulseAck();
  endtask

  task automatic test_back_to_back();
    pulseStart();
    checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL b2b_overrun_cleared: got %b expected 0", overrun); else passCount++;
    sendPixels(0, 0, RES);
    sendPixels(1, 0, RES - 1);
    checkCount++; if (newline_valid !== 1'b1) $display("[TB] FAIL b2b_pre_valid: got %b expected 1", newline_valid); else passCount++;
    pixel_data  = 8'(1 + RES - 1);
    pixel_valid = 1'b1;
    row_ack     = 1'b1;
    tick();
    pixel_valid = 1'b0;
    row_ack     = 1'b0;
    checkCount++; if (newline_valid !== 1'b1) $display("[TB] FAIL b2b_valid_no_gap: got %b expected 1", newline_valid); else passCount++;
    checkCount++; if (row_index !== 8'd1) $display("[TB] FAIL b2b_row_index: got %0d expected 1", row_index); else passCount++;
    checkCount++; if (img_buf_newline !== expRow(1)) $display("[TB] FAIL b2b_data: got %h expected %h", img_buf_newline, expRow(1)); else passCount++;
    checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun); else passCount++;
    pulseAck();
  endtask

  task automatic test_abort();
    pulseStart();
    sendPixels(0, 0, RES);
    sendPixels(1, 0, RES);
    pulseAck();
    for (int r = 2; r < 50; r++) begin
      sendPixels(r, 0, RES);
      if (r < 49) pulseAck();
    end
    sendPixels(50, 0, 30);
    checkCount++; if (newline_valid !== 1'b1) $display("[TB] FAIL abort_pre_valid: got %b expected 1", newline_valid); else passCount++;
    checkCount++; if (overrun !== 1'b1) $display("[TB] FAIL abort_pre_overrun: got %b expected 1", overrun); else passCount++;
    // Restart pulse carries column 0 of the new frame's first row.
    frame_start = 1'b1;
    pixel_data  = 8'(200);
    pixel_valid = 1'b1;
    tick();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    checkCount++; if (newline_valid !== 1'b0) $display("[TB] FAIL abort_valid: got %b expected 0", newline_valid); else passCount++;
    checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL abort_overrun: got %b expected 0", overrun); else passCount++;
    sendPixels(200, 1, RES - 1);
    checkCount++; if (newline_valid !== 1'b1) $display("[TB] FAIL abort_next_valid: got %b expected 1", newline_valid); else passCount++;
    checkCount++; if (row_index !== 8'd0) $display("[TB] FAIL abort_next_index: got %0d expected 0", row_index); else passCount++;
    checkCount++; if (img_buf_newline !== expRow(200)) $display("[TB] FAIL abort_next_data: got %h expected %h", img_buf_newline, expRow(200)); else passCount++;
  endtask

`ifdef PIXEL_BINARIZE_EN
  task automatic test_binarize();
    logic [7:0]       pat [4];
    logic [7:0]       res [4];
    logic [ROW_W-1:0] e;
    pat = '{8'h3F, 8'h40, 8'h00, 8'hFF};
    res = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    e = '0;
    threshold = 8'h40;
    pulseStart();
    for (int c = 0; c < RES; c++) begin
      pixel_data  = pat[c % 4];
      pixel_valid = 1'b1;
      e[c*PW +: PW] = res[c % 4];
      tick();
    end
    pixel_valid = 1'b0;
    checkCount++; if (img_buf_newline !== e) $display("[TB] FAIL binarize_data: got %h expected %h", img_buf_newline, e); else passCount++;
    pulseAck();
  endtask
`endif

  task automatic test_midframe_reset();
    pulseStart();
    sendPixels(7, 0, RES);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkCount++; if (newline_valid !== 1'b0) $display("[TB] FAIL mid_reset_valid: got %b expected 0", newline_valid); else passCount++;
    checkCount++; if (img_buf_newline !== '0) $display("[TB] FAIL mid_reset_line: got %h expected 0", img_buf_newline); else passCount++;
    sendPixels(9, 0, RES);
    checkCount++; if (newline_valid !== 1'b0) $display("[TB] FAIL idle_ignores_pixels: got %b expected 0", newline_valid); else passCount++;
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_full_frame();
    test_overrun();
    test_back_to_back();
    test_abort();
`ifdef PIXEL_BINARIZE_EN
    test_binarize();
`endif
    test_midframe_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
